// File: rtl/mem_pkg.sv
// Shared types and defaults for the line-fill memory responder.
// FSM state encoding, operation codes and parameter defaults.
package mem_pkg;

    localparam int ADDR_W_DEF  = 28;
    localparam int LINE_W_DEF  = 128;
    localparam int DEPTH_DEF   = 256;
    localparam int LATENCY_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

endpackage

// File: rtl/mem_line_array.sv
// Line storage: DEPTH x LINE_W, one synchronous read port, one write port.
// Storage is never reset; only the read data register is.
module mem_line_array
    import mem_pkg::*;
#(
    parameter  int LINE_W = LINE_W_DEF,
    parameter  int DEPTH  = DEPTH_DEF,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [LINE_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [LINE_W-1:0] wr_data
);

    logic [LINE_W-1:0] lines [DEPTH];

    // Line write, committed on the clock edge.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            lines[wr_idx] <= wr_data;
        end
    end

    // Registered read; holds its value until the next read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= lines[rd_idx];
        end
    end

endmodule

// File: rtl/mem_line_responder.sv
// Memory-side line-fill responder with fixed programmable latency.
// Optional protocol checker built when MEM_PROTO_CHECK_EN is defined.
module mem_line_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int LINE_W  = LINE_W_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int LATENCY = LATENCY_DEF
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [LINE_W-1:0] mem_wdata,
    output logic [LINE_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              proto_err
);

    localparam int         IDX_W  = $clog2(DEPTH);
    localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);
    localparam bit         LAT_1  = (LATENCY == 1);

    state_t            state;
    op_t               op;
    logic [7:0]        cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;

    logic              req;
    op_t               req_op;
    logic              rd_en;
    logic [IDX_W-1:0]  rd_idx;
    logic              wr_en;

    assign req    = mem_read | mem_write;
    assign req_op = mem_write ? OP_WRITE : OP_READ;
    assign wr_en  = (state == RESP) && (op == OP_WRITE);

    // Fire the array read on the edge that enters RESP.
    always_comb begin
        rd_en  = 1'b0;
        rd_idx = addr_q[IDX_W-1:0];
        unique case (state)
            IDLE: begin
                if (LAT_1 && req && req_op == OP_READ) begin
                    rd_en  = 1'b1;
                    rd_idx = mem_addr[IDX_W-1:0];
                end
            end
            BUSY: begin
                if (cnt == 8'd1 && op == OP_READ) begin
                    rd_en = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Request FSM with latency counter and registered ready pulse.
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state     <= IDLE;
            op        <= OP_READ;
            cnt       <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            mem_ready <= 1'b0;
        end else begin
            mem_ready <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req) begin
                        addr_q  <= mem_addr;
                        wdata_q <= mem_wdata;
                        op      <= req_op;
                        cnt     <= LAT_M1;
                        if (LAT_1) begin
                            state     <= RESP;
                            mem_ready <= 1'b1;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    cnt <= cnt - 8'd1;
                    if (cnt == 8'd1) begin
                        state     <= RESP;
                        mem_ready <= 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    mem_line_array #(
        .LINE_W (LINE_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk     (clk),
        .rst     (proc_reset),
        .rd_en   (rd_en),
        .rd_idx  (rd_idx),
        .rd_data (mem_rdata),
        .wr_en   (wr_en),
        .wr_idx  (addr_q[IDX_W-1:0]),
        .wr_data (wdata_q)
    );

`ifdef MEM_PROTO_CHECK_EN
    // Sticky flag: request dropped, op changed or address moved mid-flight.
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            proto_err <= 1'b0;
        end else if (state == BUSY || state == RESP) begin
            if (!req || req_op != op || mem_addr != addr_q) begin
                proto_err <= 1'b1;
            end
        end
    end
`else
    assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_line_responder.sv
// Directed self-checking bench for mem_line_responder.
// Instance a uses LATENCY=8, instance b uses LATENCY=1.
module tb_mem_line_responder;

    localparam logic [127:0] D5 = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] D7 = 128'hDEADBEEF_00000007_CAFEF00D_77777777;
    localparam logic [127:0] D9 = 128'h99999999_AAAAAAAA_55555555_00000009;
    localparam logic [127:0] X9 = 128'hFFFFFFFF_EEEEEEEE_DDDDDDDD_CCCCCCCC;
    localparam logic [127:0] D3 = 128'h33333333_12121212_34343434_00000003;
    localparam logic [127:0] D4 = 128'h44444444_00000000_44444444_00000004;

`ifdef MEM_PROTO_CHECK_EN
    localparam logic PC_EXP = 1'b1;
`else
    localparam logic PC_EXP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         a_rst, a_read, a_write, a_ready, a_perr;
    logic [27:0]  a_addr;
    logic [127:0] a_wdata, a_rdata;
    logic         b_rst, b_read, b_write, b_ready, b_perr;
    logic [27:0]  b_addr;
    logic [127:0] b_wdata, b_rdata;

    int checks = 0;
    int failures = 0;
    logic [127:0] e_lines [3];

    always #5 clk = ~clk;

    mem_line_responder #(.LATENCY(8)) dut_a (
        .clk        (clk),
        .proc_reset (a_rst),
        .mem_read   (a_read),
        .mem_write  (a_write),
        .mem_addr   (a_addr),
        .mem_wdata  (a_wdata),
        .mem_rdata  (a_rdata),
        .mem_ready  (a_ready),
        .proto_err  (a_perr)
    );

    mem_line_responder #(.LATENCY(1)) dut_b (
        .clk        (clk),
        .proc_reset (b_rst),
        .mem_read   (b_read),
        .mem_write  (b_write),
        .mem_addr   (b_addr),
        .mem_wdata  (b_wdata),
        .mem_rdata  (b_rdata),
        .mem_ready  (b_ready),
        .proto_err  (b_perr)
    );

    task automatic drive(input bit b, input logic rd, input logic wr,
                         input logic [27:0] ad, input logic [127:0] wd);
        if (b) begin
            b_read = rd; b_write = wr; b_addr = ad; b_wdata = wd;
        end else begin
            a_read = rd; a_write = wr; a_addr = ad; a_wdata = wd;
        end
    endtask

    // One transaction; expects ready only in cycle lat, rdata==exp from
    // the ready cycle through three cycles after it.
    task automatic txn(input bit b, input logic rd, input logic wr,
                       input logic [27:0] ad, input logic [127:0] wd,
                       input logic [127:0] exp, input string nm);
        int lat;
        int bad_c;
        logic rdy;
        logic [127:0] rdat;
        logic [127:0] bad_d;
        bit bad_r;
        bit bad_dv;
        lat = b ? 1 : 8;
        bad_r = 0; bad_dv = 0; bad_c = 0; bad_d = '0;
        drive(b, rd, wr, ad, wd);
        for (int c = 1; c <= lat + 3; c++) begin
            @(posedge clk); #1;
            if (c == lat + 1) drive(b, 1'b0, 1'b0, ad, wd);
            rdy  = b ? b_ready : a_ready;
            rdat = b ? b_rdata : a_rdata;
            if (rdy !== 1'(c == lat) && !bad_r) begin
                bad_r = 1; bad_c = c;
            end
            if (c >= lat && rdat !== exp && !bad_dv) begin
                bad_dv = 1; bad_d = rdat;
            end
        end
        checks++;
        if (bad_r) begin
            failures++;
            $display("FAIL %s_ready: wrong ready in cycle %0d, want only %0d",
                     nm, bad_c, lat);
        end
        checks++;
        if (bad_dv) begin
            failures++;
            $display("FAIL %s_rdata: got %h want %h", nm, bad_d, exp);
        end
    endtask

    task automatic test_reset;
        a_rst = 1; b_rst = 1;
        drive(0, 0, 0, '0, '0);
        drive(1, 0, 0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({a_ready, b_ready, a_perr, b_perr} !== 4'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b want 0000",
                     {a_ready, b_ready, a_perr, b_perr});
        end
        checks++;
        if (a_rdata !== '0 || b_rdata !== '0) begin
            failures++;
            $display("FAIL reset_rdata: got %h / %h want 0", a_rdata, b_rdata);
        end
        a_rst = 0; b_rst = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read;
        txn(0, 0, 1, 28'h0000005, D5, '0, "wr5");
        txn(0, 1, 0, 28'h0000005, '0, D5, "rd5");
    endtask

    task automatic test_both_high;
        txn(0, 1, 1, 28'h0000007, D7, D5, "both7");
        txn(0, 1, 0, 28'h0000007, '0, D7, "rd7");
    endtask

    task automatic test_alias;
        txn(0, 0, 1, 28'h0000009, D9, D7, "wr9");
        txn(0, 0, 1, 28'h0000003, D3, D7, "wr3");
        txn(0, 0, 1, 28'h0000004, D4, D7, "wr4");
        txn(0, 1, 0, 28'h0000105, '0, D5, "alias105");
    endtask

    task automatic test_reset_mid;
        bit bad;
        bad = 0;
        drive(0, 0, 1, 28'h0000009, X9);
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (c == 4) begin
                a_rst = 1;
                drive(0, 0, 0, 28'h0000009, X9);
            end
            if (c == 5) a_rst = 0;
            if (a_ready !== 1'b0) bad = 1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL rstmid_ready: ready pulsed, want none");
        end
        checks++;
        if (a_rdata !== '0) begin
            failures++;
            $display("FAIL rstmid_rdata: got %h want 0", a_rdata);
        end
        txn(0, 1, 0, 28'h0000009, '0, D9, "rd9_after_rst");
    endtask

    task automatic test_back_to_back;
        bit bad_r;
        bit bad_d;
        logic [127:0] got;
        logic [127:0] want;
        bad_r = 0; bad_d = 0; got = '0; want = '0;
        for (int i = 0; i < 3; i++) begin
            txn(1, 0, 1, 28'(32'h10 + i), e_lines[i], '0, "b_wr");
        end
        drive(1, 1, 0, 28'h0000010, '0);
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            if (b_ready !== 1'(c % 2)) bad_r = 1;
            if (c % 2 == 1 && b_rdata !== e_lines[(c - 1) / 2] && !bad_d) begin
                bad_d = 1; got = b_rdata; want = e_lines[(c - 1) / 2];
            end
            if (c == 2 || c == 4) b_addr = 28'(32'h10 + c / 2);
            if (c == 6) b_read = 0;
        end
        checks++;
        if (bad_r) begin
            failures++;
            $display("FAIL b2b_ready: ready not every 2nd cycle");
        end
        checks++;
        if (bad_d) begin
            failures++;
            $display("FAIL b2b_rdata: got %h want %h", got, want);
        end
        checks++;
        if (b_perr !== 1'b0) begin
            failures++;
            $display("FAIL b2b_proto: got %b want 0", b_perr);
        end
    endtask

    task automatic test_proto_check;
        bit bad_r;
        logic [127:0] got;
        bad_r = 0; got = '0;
        checks++;
        if (a_perr !== 1'b0) begin
            failures++;
            $display("FAIL proto_clean: got %b want 0", a_perr);
        end
        drive(0, 1, 0, 28'h0000003, '0);
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (c == 3) a_addr = 28'h0000004;
            if (c == 9) a_read = 0;
            if (a_ready !== 1'(c == 8)) bad_r = 1;
            if (c == 8) got = a_rdata;
        end
        checks++;
        if (bad_r) begin
            failures++;
            $display("FAIL proto_ready: ready not only in cycle 8");
        end
        checks++;
        if (got !== D3) begin
            failures++;
            $display("FAIL proto_rdata: got %h want %h", got, D3);
        end
        checks++;
        if (a_perr !== PC_EXP) begin
            failures++;
            $display("FAIL proto_flag: got %b want %b", a_perr, PC_EXP);
        end
        a_rst = 1;
        @(posedge clk); #1;
        a_rst = 0;
        checks++;
        if (a_perr !== 1'b0) begin
            failures++;
            $display("FAIL proto_cleared: got %b want 0", a_perr);
        end
    endtask

    initial begin
        e_lines[0] = 128'hA0A0A0A0_00000010_1111_2222_3333_4444;
        e_lines[1] = 128'hB1B1B1B1_00000011_5555_6666_7777_8888;
        e_lines[2] = 128'hC2C2C2C2_00000012_9999_AAAA_BBBB_CCCC;
        test_reset();
        test_write_read();
        test_both_high();
        test_alias();
        test_reset_mid();
        test_back_to_back();
        test_proto_check();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
